// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and helpers for the matrix stream loader family.
// Holds the load FSM state encoding, the default geometry of the production
// configuration (DPE, ROW_W, row_t) and small constant helpers used to size
// counters and address ports from module parameters.
package matrix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    READY,
    DRAIN
  } load_state_t;

  localparam int ELEM_W_DEF = 8;
  localparam int IN_W_DEF   = 2;
  localparam int K_DEF      = 32;
  localparam int A_ROWS_DEF = 32;
  localparam int B_COLS_DEF = 32;

  // Geometry of the default configuration; parameterised instances derive
  // their own equivalents locally from their parameters.
  localparam int DPE   = ELEM_W_DEF / IN_W_DEF;
  localparam int ROW_W = K_DEF * ELEM_W_DEF;

  typedef logic [ROW_W-1:0] row_t;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/row_store.sv
// row_store: A and B row/column storage.
// Two inferred arrays (A: A_ROWS rows, B: B_COLS columns), each with one
// write port and a shared registered read port (1-cycle latency).
// Contents are not reset.
//   eth_refclk  clock
//   we_a/we_b   write strobe into A or B at waddr
//   waddr/wdata write address and row data
//   re          read enable; rsel 0 = A, 1 = B; raddr read address
//   rdata       registered read data
module row_store
  import matrix_pkg::*;
#(
  parameter int ROW_W  = matrix_pkg::ROW_W,
  parameter int A_ROWS = A_ROWS_DEF,
  parameter int B_COLS = B_COLS_DEF,
  parameter int IDX_W  = clog2_min1(max2(A_ROWS, B_COLS))
) (
  input  logic             eth_refclk,
  input  logic             we_a,
  input  logic             we_b,
  input  logic [IDX_W-1:0] waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic             re,
  input  logic             rsel,
  input  logic [IDX_W-1:0] raddr,
  output logic [ROW_W-1:0] rdata
);

  localparam int AW = clog2_min1(A_ROWS);
  localparam int BW = clog2_min1(B_COLS);

  logic [ROW_W-1:0] mem_a [A_ROWS];
  logic [ROW_W-1:0] mem_b [B_COLS];

  always_ff @(posedge eth_refclk) begin
    if (we_a) mem_a[waddr[AW-1:0]] <= wdata;
    if (we_b) mem_b[waddr[BW-1:0]] <= wdata;
    if (re) begin
      if (rsel) rdata <= mem_b[raddr[BW-1:0]];
      else      rdata <= mem_a[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: deserialises an IN_W-bit stream into ELEM_W-bit
// elements, packs A rows then B columns into row_store, then serves
// 1-cycle-latency random row/column reads once a full frame has landed.
//   eth_refclk, rst        clock, async active-high reset
//   axiiv, axiid           stream valid / data (element MSB first)
//   rd_req/rd_sel/rd_idx   read request, select (0 A, 1 B), index
//   rd_valid/rd_oob        response valid, index out of range
//   rd_idx_out/rd_sel_out  echoed request fields
//   rd_data                row data, element 0 in the MSBs
//   complete/error/busy    loaded, last frame short, frame in progress
//
// state  | meaning
// IDLE   | waiting for a frame start (axiiv rising)
// LOAD_A | filling A rows
// LOAD_B | filling B columns
// READY  | both matrices loaded, reads served
// DRAIN  | frame was in flight at reset release; wait for axiiv low
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int K      = K_DEF,
  parameter int A_ROWS = A_ROWS_DEF,
  parameter int B_COLS = B_COLS_DEF,
  parameter int IDX_W  = clog2_min1(max2(A_ROWS, B_COLS))
) (
  input  logic                eth_refclk,
  input  logic                rst,
  input  logic                axiiv,
  input  logic [IN_W-1:0]     axiid,
  input  logic                rd_req,
  input  logic                rd_sel,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic                rd_oob,
  output logic [IDX_W-1:0]    rd_idx_out,
  output logic                rd_sel_out,
  output logic [K*ELEM_W-1:0] rd_data,
  output logic                complete,
  output logic                error,
  output logic                busy
);

  localparam int DPE_N    = ELEM_W / IN_W;
  localparam int ROW_BITS = K * ELEM_W;
  localparam int DW       = clog2_min1(DPE_N);
  localparam int EW       = clog2_min1(K);
  localparam int SH_W     = (DPE_N > 1) ? ELEM_W - IN_W : 1;

  load_state_t         state;
  logic                axiiv_q;
  logic [DW-1:0]       dibit_cnt;
  logic [EW-1:0]       elem_cnt;
  logic [IDX_W-1:0]    row_cnt;
  logic [SH_W-1:0]     shift_q;
  logic [ROW_BITS-1:0] row_buf;
  logic [ROW_BITS-1:0] row_next;
  logic [ROW_BITS-1:0] store_q;
  logic [ELEM_W-1:0]   new_elem;

  logic in_load, start, take, elem_done, row_done;
  logic rd_acc, rd_is_oob;

  // A frame is only recognised on a rising axiiv edge, so trailing data in
  // READY and a frame already running at reset release are both ignored.
  assign in_load   = (state == LOAD_A) || (state == LOAD_B);
  assign start     = axiiv && !axiiv_q && ((state == IDLE) || (state == READY));
  assign take      = start || (in_load && axiiv);
  assign elem_done = take && (dibit_cnt == DW'(DPE_N - 1));
  assign row_done  = elem_done && (elem_cnt == EW'(K - 1));

  if (DPE_N > 1) begin : g_shift
    assign new_elem = {shift_q, axiid};
  end else begin : g_noshift
    assign new_elem = axiid;
  end

  // Row including the element completing this cycle, so the K-th element
  // lands in the store in the same cycle it finishes.
  always_comb begin
    row_next = row_buf;
    row_next[ROW_BITS-1-int'(elem_cnt)*ELEM_W -: ELEM_W] = new_elem;
  end

  assign rd_acc    = rd_req && complete;
  assign rd_is_oob = rd_sel ? (int'(rd_idx) >= B_COLS) : (int'(rd_idx) >= A_ROWS);

  row_store #(
    .ROW_W (ROW_BITS),
    .A_ROWS(A_ROWS),
    .B_COLS(B_COLS),
    .IDX_W (IDX_W)
  ) u_row_store (
    .eth_refclk(eth_refclk),
    .we_a      (row_done && (state != LOAD_B)),
    .we_b      (row_done && (state == LOAD_B)),
    .waddr     (row_cnt),
    .wdata     (row_next),
    .re        (rd_acc && !rd_is_oob),
    .rsel      (rd_sel),
    .raddr     (rd_idx),
    .rdata     (store_q)
  );

  // Store output is not reset; gate so out-of-range and idle beats read 0.
  assign rd_data = (rd_valid && !rd_oob) ? store_q : '0;

  always_ff @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      axiiv_q    <= 1'b1;
      dibit_cnt  <= '0;
      elem_cnt   <= '0;
      row_cnt    <= '0;
      shift_q    <= '0;
      row_buf    <= '0;
      complete   <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_oob     <= 1'b0;
      rd_idx_out <= '0;
      rd_sel_out <= 1'b0;
    end else begin
      axiiv_q <= axiiv;

      if (take) begin
        shift_q <= new_elem[SH_W-1:0];
        if (elem_done) begin
          dibit_cnt <= '0;
          row_buf   <= row_next;
          elem_cnt  <= row_done ? '0 : elem_cnt + 1'b1;
        end else begin
          dibit_cnt <= dibit_cnt + 1'b1;
        end
      end

      case (state)
        IDLE, READY: begin
          if (start) begin
            state    <= LOAD_A;
            complete <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
          end else if (state == IDLE && axiiv && axiiv_q) begin
            state <= DRAIN;
          end
        end
        LOAD_A, LOAD_B: begin
          if (!axiiv) begin
            state     <= IDLE;
            error     <= 1'b1;
            complete  <= 1'b0;
            busy      <= 1'b0;
            dibit_cnt <= '0;
            elem_cnt  <= '0;
            row_cnt   <= '0;
          end else if (row_done) begin
            if (state == LOAD_A && row_cnt == IDX_W'(A_ROWS - 1)) begin
              state   <= LOAD_B;
              row_cnt <= '0;
            end else if (state == LOAD_B && row_cnt == IDX_W'(B_COLS - 1)) begin
              state    <= READY;
              row_cnt  <= '0;
              complete <= 1'b1;
              busy     <= 1'b0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!axiiv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      rd_valid <= rd_acc;
      rd_oob   <= rd_acc && rd_is_oob;
      if (rd_acc) begin
        rd_idx_out <= rd_idx;
        rd_sel_out <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;

  localparam int ELEM_W = 8;
  localparam int IN_W   = 2;
  localparam int K      = 4;
  localparam int A_ROWS = 2;
  localparam int B_COLS = 2;
  localparam int IDX_W  = 2;

  logic                eth_refclk;
  logic                rst;
  logic                axiiv;
  logic [IN_W-1:0]     axiid;
  logic                rd_req;
  logic                rd_sel;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_valid;
  logic                rd_oob;
  logic [IDX_W-1:0]    rd_idx_out;
  logic                rd_sel_out;
  logic [K*ELEM_W-1:0] rd_data;
  logic                complete;
  logic                error;
  logic                busy;

  int vectors = 0;
  int miscompares = 0;

  matrix_stream_loader #(
    .ELEM_W(ELEM_W), .IN_W(IN_W), .K(K),
    .A_ROWS(A_ROWS), .B_COLS(B_COLS), .IDX_W(IDX_W)
  ) dut (
    .eth_refclk(eth_refclk),
    .rst       (rst),
    .axiiv     (axiiv),
    .axiid     (axiid),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_oob    (rd_oob),
    .rd_idx_out(rd_idx_out),
    .rd_sel_out(rd_sel_out),
    .rd_data   (rd_data),
    .complete  (complete),
    .error     (error),
    .busy      (busy)
  );

  initial eth_refclk = 1'b0;
  always #5 eth_refclk = ~eth_refclk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge eth_refclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_oob"}, 32'(rd_oob), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_rd_idx_out"}, 32'(rd_idx_out), 32'd0);
    chk({tag, "_rd_sel_out"}, 32'(rd_sel_out), 32'd0);
    chk({tag, "_complete"}, 32'(complete), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Full 16-element frame, element e = first + e*step; axiiv left high.
  task automatic send_frame(input logic [7:0] first, input int step);
    logic [7:0] b;
    for (int e = 0; e < 16; e++) begin
      b = first + 8'(e * step);
      for (int j = 0; j < 4; j++) begin
        axiiv = 1'b1;
        axiid = b[7-2*j -: 2];
        if (e == 15 && j == 3) chk("complete_before_last", 32'(complete), 32'd0);
        tick();
        if (e == 0 && j == 0) begin
          chk("busy_after_start", 32'(busy), 32'd1);
          chk("complete_after_start", 32'(complete), 32'd0);
        end
      end
    end
    chk("complete_after_last", 32'(complete), 32'd1);
    chk("busy_after_last", 32'(busy), 32'd0);
    chk("error_after_last", 32'(error), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic sel, input logic [IDX_W-1:0] idx,
                         input logic exp_oob, input logic [31:0] exp_data);
    rd_req = 1'b1;
    rd_sel = sel;
    rd_idx = idx;
    tick();
    rd_req = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_oob"}, 32'(rd_oob), 32'(exp_oob));
    chk({tag, "_data"}, rd_data, exp_data);
    chk({tag, "_idx_echo"}, 32'(rd_idx_out), 32'(idx));
    chk({tag, "_sel_echo"}, 32'(rd_sel_out), 32'(sel));
  endtask

  initial begin
    rst = 1'b1;
    axiiv = 1'b0;
    axiid = '0;
    rd_req = 1'b0;
    rd_sel = 1'b0;
    rd_idx = '0;
    #12;
    chk_all_zero("reset");
    @(negedge eth_refclk);
    rst = 1'b0;
    tick();
    tick();

    // Full load 0x01..0x10 and readback
    send_frame(8'h01, 1);
    axiiv = 1'b0;
    tick();
    do_read("a0", 1'b0, 2'd0, 1'b0, 32'h01020304);
    do_read("a1", 1'b0, 2'd1, 1'b0, 32'h05060708);
    do_read("b0", 1'b1, 2'd0, 1'b0, 32'h090A0B0C);
    do_read("b1", 1'b1, 2'd1, 1'b0, 32'h0D0E0F10);

    // Out-of-range indices
    do_read("oob_a3", 1'b0, 2'd3, 1'b1, 32'h0);
    do_read("oob_b2", 1'b1, 2'd2, 1'b1, 32'h0);

    // Back-to-back reads
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = 2'd0;
    tick();
    chk("b2b0_valid", 32'(rd_valid), 32'd1);
    chk("b2b0_data", rd_data, 32'h01020304);
    rd_idx = 2'd1;
    tick();
    chk("b2b1_valid", 32'(rd_valid), 32'd1);
    chk("b2b1_data", rd_data, 32'h05060708);
    rd_idx = 2'd0;
    tick();
    chk("b2b2_valid", 32'(rd_valid), 32'd1);
    chk("b2b2_data", rd_data, 32'h01020304);
    rd_req = 1'b0;
    tick();
    chk("b2b_end_valid", 32'(rd_valid), 32'd0);

    // Trailing data after a full frame is ignored
    send_frame(8'h01, 1);
    axiid = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    chk("trail_complete", 32'(complete), 32'd1);
    chk("trail_busy", 32'(busy), 32'd0);
    do_read("trail_a1", 1'b0, 2'd1, 1'b0, 32'h05060708);
    do_read("trail_b1", 1'b1, 2'd1, 1'b0, 32'h0D0E0F10);
    axiiv = 1'b0;
    tick();
    send_frame(8'hFF, -1);
    axiiv = 1'b0;
    tick();
    do_read("new_a0", 1'b0, 2'd0, 1'b0, 32'hFFFEFDFC);
    do_read("new_b1", 1'b1, 2'd1, 1'b0, 32'hF3F2F1F0);

    // Read coinciding with frame start, then a short frame
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = 2'd1;
    axiiv = 1'b1; axiid = 2'd0;
    tick();
    chk("start_rd_valid", 32'(rd_valid), 32'd1);
    chk("start_rd_data", rd_data, 32'hFBFAF9F8);
    chk("start_complete", 32'(complete), 32'd0);
    axiid = 2'd1;
    tick();
    rd_req = 1'b0;
    chk("start_rd2_dropped", 32'(rd_valid), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    for (int i = 2; i < 30; i++) begin
      axiid = 2'(i);
      tick();
    end
    axiiv = 1'b0;
    tick();
    chk("short_error", 32'(error), 32'd1);
    chk("short_complete", 32'(complete), 32'd0);
    chk("short_busy", 32'(busy), 32'd0);
    rd_req = 1'b1; rd_sel = 1'b0; rd_idx = 2'd0;
    tick();
    rd_req = 1'b0;
    chk("short_rd_dropped", 32'(rd_valid), 32'd0);
    tick();
    chk("short_rd_dropped2", 32'(rd_valid), 32'd0);

    // Async reset mid LOAD_B, then drain and a clean reload
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'h21 + 8'(i / 4);
      axiiv = 1'b1;
      axiid = b[7-2*(i%4) -: 2];
      tick();
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge eth_refclk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      axiid = 2'(i);
      tick();
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_complete", 32'(complete), 32'd0);
    chk("drain_error", 32'(error), 32'd0);
    axiiv = 1'b0;
    tick();
    send_frame(8'h31, 1);
    axiiv = 1'b0;
    tick();
    do_read("rl_a0", 1'b0, 2'd0, 1'b0, 32'h31323334);
    do_read("rl_a1", 1'b0, 2'd1, 1'b0, 32'h35363738);
    do_read("rl_b1", 1'b1, 2'd1, 1'b0, 32'h3D3E3F40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
